// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM breathing generator.
package pwm_pkg;

    // Width of the zero-extended counter and duty outputs
    localparam int unsigned PWM_OUT_W = 32;

    // Breathing FSM states; the encoding is visible on the debug state output
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RAMP_UP   = 3'd1,
        HOLD_HIGH = 3'd2,
        RAMP_DOWN = 3'd3,
        HOLD_LOW  = 3'd4
    } pwm_state_t;

endpackage

// File: rtl/pwm_period_counter.sv
// Free-running PWM period counter with a registered period_tick and a
// combinational boundary strobe marking the edge where the counter wraps.
module pwm_period_counter #(
    parameter int unsigned PERIOD_LOG2 = 10
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clear_i,
    input  logic                   run_i,
    output logic [PERIOD_LOG2-1:0] count_o,
    output logic [PERIOD_LOG2-1:0] count_next_o,
    output logic                   tick_o,
    output logic                   boundary_o
);

    localparam logic [PERIOD_LOG2-1:0] LAST = '1;

    logic [PERIOD_LOG2-1:0] count_q;
    logic [PERIOD_LOG2-1:0] count_d;
    logic                   tick_q;

    // Boundary is the edge leaving the last count of a running period
    assign boundary_o = run_i && !clear_i && (count_q == LAST);

    // Next count: cleared on stop, held at 0 while idle, wraps at PERIOD-1
    always_comb begin
        count_d = '0;
        if (!clear_i && run_i) begin
            if (count_q == LAST) begin
                count_d = '0;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    // Count register and tick pulse aligned with the counter's 0 cycle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            tick_q  <= !clear_i && (count_d == '0);
        end
    end

    assign count_o      = count_q;
    assign count_next_o = count_d;
    assign tick_o       = tick_q;

endmodule

// File: rtl/pwm_breath_gen.sv
// Breathing PWM generator: period counter plus a duty FSM that ramps up,
// holds, ramps down and holds in a loop. Duty only changes at period
// boundaries. Optional quadratic duty curve: define PWM_BREATH_GAMMA_EN.
module pwm_breath_gen
    import pwm_pkg::*;
#(
    parameter int unsigned PERIOD_LOG2  = 10,
    parameter int unsigned STEP         = 16,
    parameter int unsigned HOLD_PERIODS = 50
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    output logic [PWM_OUT_W-1:0] counter,
    output logic                 on,
    output logic [PWM_OUT_W-1:0] duty,
    output logic                 period_tick,
    output logic [2:0]           state
);

    localparam int unsigned DW        = PERIOD_LOG2 + 1;
    localparam int unsigned SW        = PERIOD_LOG2 + 2;
    localparam int unsigned PERIOD    = 1 << PERIOD_LOG2;
    localparam int unsigned STEP_CLMP = (STEP > PERIOD) ? PERIOD : STEP;
    localparam int unsigned HW        = $clog2(HOLD_PERIODS + 1);

    localparam logic [DW-1:0] PERIOD_D  = {1'b1, {PERIOD_LOG2{1'b0}}};
    localparam logic [DW-1:0] STEP_D    = DW'(STEP_CLMP);
    localparam logic [SW-1:0] STEP_S    = SW'(STEP_CLMP);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_PERIODS - 1);

    pwm_state_t              state_q, state_d;
    logic [DW-1:0]           duty_q, duty_d;
    logic [HW-1:0]           hold_q, hold_d;
    logic                    on_q, on_d;
    logic [DW-1:0]           eff_d;
    logic [SW-1:0]           up_sum;
    logic [DW-1:0]           up_sat;
    logic [DW-1:0]           down_sat;

    logic [PERIOD_LOG2-1:0]  cnt_q, cnt_d;
    logic                    tick, boundary;

    pwm_period_counter #(
        .PERIOD_LOG2 (PERIOD_LOG2)
    ) u_counter (
        .clk_i        (clk),
        .rst_ni       (reset),
        .clear_i      (!enable),
        .run_i        (state_q != IDLE),
        .count_o      (cnt_q),
        .count_next_o (cnt_d),
        .tick_o       (tick),
        .boundary_o   (boundary)
    );

    // Saturating ramp arithmetic; the extra top bit of up_sum catches overflow
    always_comb begin
        up_sum = {1'b0, duty_q} + STEP_S;
        if (up_sum >= {1'b0, PERIOD_D}) begin
            up_sat = PERIOD_D;
        end else begin
            up_sat = up_sum[DW-1:0];
        end
        if (duty_q <= STEP_D) begin
            down_sat = '0;
        end else begin
            down_sat = duty_q - STEP_D;
        end
    end

    // Next-state, duty and hold-count logic; all changes happen on boundaries
    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        hold_d  = hold_q;
        if (!enable) begin
            state_d = IDLE;
            duty_d  = '0;
            hold_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = RAMP_UP;
                    duty_d  = '0;
                    hold_d  = '0;
                end
                RAMP_UP: begin
                    if (boundary) begin
                        duty_d = up_sat;
                        if (up_sat == PERIOD_D) begin
                            state_d = HOLD_HIGH;
                        end
                    end
                end
                RAMP_DOWN: begin
                    if (boundary) begin
                        duty_d = down_sat;
                        if (down_sat == '0) begin
                            state_d = HOLD_LOW;
                        end
                    end
                end
                HOLD_HIGH, HOLD_LOW: begin
                    if (boundary) begin
                        if (hold_q == HOLD_LAST) begin
                            hold_d  = '0;
                            state_d = (state_q == HOLD_HIGH) ? RAMP_DOWN : RAMP_UP;
                        end else begin
                            hold_d = hold_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    duty_d  = '0;
                    hold_d  = '0;
                end
            endcase
        end
    end

    // Effective duty; derived from next duty so it is latched along with duty
`ifdef PWM_BREATH_GAMMA_EN
    always_comb begin
        eff_d = DW'(({{DW{1'b0}}, duty_d} * {{DW{1'b0}}, duty_d}) >> PERIOD_LOG2);
    end
`else
    always_comb begin
        eff_d = duty_d;
    end
`endif

    // PWM level from next counter and next duty keeps on aligned with counter
    always_comb begin
        on_d = ({1'b0, cnt_d} < eff_d);
    end

    // FSM and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            duty_q  <= '0;
            hold_q  <= '0;
            on_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            hold_q  <= hold_d;
            on_q    <= on_d;
        end
    end

    assign counter     = PWM_OUT_W'(cnt_q);
    assign duty        = PWM_OUT_W'(duty_q);
    assign on          = on_q;
    assign period_tick = tick;
    assign state       = state_q;

endmodule

// File: tb/tb_pwm_breath_gen.sv
// Directed bench for pwm_breath_gen with PERIOD_LOG2=4, HOLD_PERIODS=2:
// instance a uses STEP=4, instance b uses STEP=5 for saturation.
module tb_pwm_breath_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        en_a, en_b;
    logic [31:0] a_counter, a_duty, b_counter, b_duty;
    logic        a_on, a_tick, b_on, b_tick;
    logic [2:0]  a_state, b_state;

    int unsigned errors = 0;
    int unsigned checks = 0;

    int unsigned exp_duty  [14] = '{0, 4, 8, 12, 16, 16, 16, 12, 8, 4, 0, 0, 0, 4};
    int unsigned exp_state [14] = '{1, 1, 1, 1, 2, 2, 3, 3, 3, 3, 4, 4, 1, 1};
    int unsigned sat_duty  [11] = '{0, 5, 10, 15, 16, 16, 16, 11, 6, 1, 0};
    int unsigned sat_state [11] = '{1, 1, 1, 1, 2, 2, 3, 3, 3, 3, 4};

    always #5 clk = ~clk;

    pwm_breath_gen #(
        .PERIOD_LOG2  (4),
        .STEP         (4),
        .HOLD_PERIODS (2)
    ) dut_a (
        .clk         (clk),
        .reset       (reset),
        .enable      (en_a),
        .counter     (a_counter),
        .on          (a_on),
        .duty        (a_duty),
        .period_tick (a_tick),
        .state       (a_state)
    );

    pwm_breath_gen #(
        .PERIOD_LOG2  (4),
        .STEP         (5),
        .HOLD_PERIODS (2)
    ) dut_b (
        .clk         (clk),
        .reset       (reset),
        .enable      (en_b),
        .counter     (b_counter),
        .on          (b_on),
        .duty        (b_duty),
        .period_tick (b_tick),
        .state       (b_state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Duty actually compared against the counter
    function automatic int unsigned eff(input int unsigned d);
`ifdef PWM_BREATH_GAMMA_EN
        return (d * d) >> 4;
`else
        return d;
`endif
    endfunction

    initial begin
        reset = 1'b0;
        en_a  = 1'b0;
        en_b  = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_counter", a_counter, 0);
        check("rst_duty",    a_duty,    0);
        check("rst_on",      32'(a_on),   0);
        check("rst_tick",    32'(a_tick), 0);
        check("rst_state",   32'(a_state), 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_counter", a_counter, 0);
        check("idle_state",   32'(a_state), 0);
        check("idle_tick",    32'(a_tick), 0);

        // Start and full breathing cycle, every cycle of 14 periods
        en_a = 1'b1;
        @(negedge clk);
        for (int p = 0; p < 14; p++) begin
            for (int c = 0; c < 16; c++) begin
                check($sformatf("p%0d_c%0d_counter", p + 1, c), a_counter, 32'(c));
                check($sformatf("p%0d_c%0d_duty", p + 1, c), a_duty, exp_duty[p]);
                check($sformatf("p%0d_c%0d_on", p + 1, c), 32'(a_on),
                      32'(32'(c) < eff(exp_duty[p])));
                check($sformatf("p%0d_c%0d_tick", p + 1, c), 32'(a_tick), 32'(c == 0));
                if (c == 0 || c == 15) begin
                    check($sformatf("p%0d_c%0d_state", p + 1, c), 32'(a_state), exp_state[p]);
                end
                @(negedge clk);
            end
        end

        // Enable drop at counter 7 during RAMP_UP (period 15, duty 8)
        repeat (7) @(negedge clk);
        check("drop_pre_counter", a_counter, 7);
        check("drop_pre_duty",    a_duty,    8);
        check("drop_pre_state",   32'(a_state), 1);
        check("drop_pre_on",      32'(a_on), 32'(7 < eff(8)));
        en_a = 1'b0;
        @(negedge clk);
        check("drop_counter", a_counter, 0);
        check("drop_on",      32'(a_on), 0);
        check("drop_duty",    a_duty, 0);
        check("drop_state",   32'(a_state), 0);
        check("drop_tick",    32'(a_tick), 0);

        // Saturation with STEP=5
        en_b = 1'b1;
        @(negedge clk);
        for (int p = 0; p < 11; p++) begin
            check($sformatf("sat_p%0d_counter", p + 1), b_counter, 0);
            check($sformatf("sat_p%0d_tick", p + 1), 32'(b_tick), 1);
            check($sformatf("sat_p%0d_duty", p + 1), b_duty, sat_duty[p]);
            check($sformatf("sat_p%0d_state", p + 1), 32'(b_state), sat_state[p]);
            repeat (16) @(negedge clk);
        end
        en_b = 1'b0;

        // Asynchronous reset mid-period
        en_a = 1'b1;
        repeat (20) @(negedge clk);
        check("mid_pre_counter", a_counter, 3);
        check("mid_pre_duty",    a_duty, 4);
        check("mid_pre_on",      32'(a_on), 32'(3 < eff(4)));
        #2 reset = 1'b0;
        #1;
        check("arst_counter", a_counter, 0);
        check("arst_duty",    a_duty, 0);
        check("arst_on",      32'(a_on), 0);
        check("arst_tick",    32'(a_tick), 0);
        check("arst_state",   32'(a_state), 0);
        en_a = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("post_counter", a_counter, 0);
        check("post_duty",    a_duty, 0);
        check("post_on",      32'(a_on), 0);
        check("post_tick",    32'(a_tick), 0);
        check("post_state",   32'(a_state), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
